snake_turn_ctrl: RTL

SNAKE_TURN_CTRL -- requirements
Module: snake_turn_ctrl

---
 rtl/snake_turn_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/snake_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : snake_turn_ctrl
// Description : Two-player snakes-and-ladders turn sequencer with LFSR dice,
//               move-engine handshake, six rule and response timeout.
// Revision    : 1.0  initial release
// ============================================================================
module snake_turn_ctrl #(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          RESP_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       roll_btn,
    input  logic       dice_force_en,
    input  logic [2:0] dice_force,
    output logic       mv_req_valid,
    output logic [6:0] mv_position,
    output logic [2:0] mv_dice,
    input  logic       mv_resp_valid,
    input  logic [6:0] mv_new_position,
    output logic       cur_player,
    output logic [6:0] p0_pos,
    output logic [6:0] p1_pos,
    output logic [2:0] last_roll,
    output logic       busy,
    output logic       game_over,
    output logic       winner,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ROLL   = 3'd1,
        S_REQ    = 3'd2,
        S_WAIT   = 3'd3,
        S_UPDATE = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int                  C_WCNT_W    = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT);
    localparam logic [C_WCNT_W-1:0] C_WCNT_LAST = C_WCNT_W'(RESP_TIMEOUT - 1);
    localparam logic [6:0]          C_WIN_SQ    = 7'd100;

    state_t              r_state_q,     w_state_d;
    logic [15:0]         r_lfsr_q,      w_lfsr_d;
    logic [6:0]          r_p0_pos_q,    w_p0_pos_d;
    logic [6:0]          r_p1_pos_q,    w_p1_pos_d;
    logic                r_cur_q,       w_cur_d;
    logic [2:0]          r_last_roll_q, w_last_roll_d;
    logic [1:0]          r_six_q,       w_six_d;
    logic [C_WCNT_W-1:0] r_wcnt_q,      w_wcnt_d;
    logic [6:0]          r_resp_pos_q,  w_resp_pos_d;
    logic                r_resp_ok_q,   w_resp_ok_d;
    logic                r_timeout_q,   w_timeout_d;
    logic                r_winner_q,    w_winner_d;
    logic                r_err_q,       w_err_d;

    logic [2:0]          w_cand;
    logic [6:0]          w_cur_pos;
    logic                w_won;

    assign w_cand    = dice_force_en ? dice_force : r_lfsr_q[2:0];
    assign w_cur_pos = r_cur_q ? r_p1_pos_q : r_p0_pos_q;
    assign w_won     = r_resp_ok_q && (r_resp_pos_q == C_WIN_SQ);

    always_comb begin
        w_state_d     = r_state_q;
        w_lfsr_d      = {r_lfsr_q[14:0], r_lfsr_q[15] ^ r_lfsr_q[13] ^ r_lfsr_q[12] ^ r_lfsr_q[10]};
        w_p0_pos_d    = r_p0_pos_q;
        w_p1_pos_d    = r_p1_pos_q;
        w_cur_d       = r_cur_q;
        w_last_roll_d = r_last_roll_q;
        w_six_d       = r_six_q;
        w_wcnt_d      = r_wcnt_q;
        w_resp_pos_d  = r_resp_pos_q;
        w_resp_ok_d   = r_resp_ok_q;
        w_timeout_d   = r_timeout_q;
        w_winner_d    = r_winner_q;
        w_err_d       = r_err_q;

        case (r_state_q)
            S_IDLE: begin
                if (roll_btn) w_state_d = S_ROLL;
            end
            S_ROLL: begin
                if (w_cand != 3'd0 && w_cand != 3'd7) begin
                    w_last_roll_d = w_cand;
                    // Third six in a row forfeits the move and passes the turn.
                    if (w_cand == 3'd6 && r_six_q == 2'd2) begin
                        w_six_d   = 2'd0;
                        w_cur_d   = ~r_cur_q;
                        w_state_d = S_IDLE;
                    end else begin
                        w_state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                w_wcnt_d    = '0;
                w_timeout_d = 1'b0;
                w_resp_ok_d = 1'b0;
                w_state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (mv_resp_valid) begin
                    if (mv_new_position > C_WIN_SQ) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_resp_ok_d  = 1'b1;
                        w_resp_pos_d = mv_new_position;
                    end
                    w_state_d = S_UPDATE;
                end else if (r_wcnt_q == C_WCNT_LAST) begin
                    w_err_d     = 1'b1;
                    w_timeout_d = 1'b1;
                    w_state_d   = S_UPDATE;
                end else begin
                    w_wcnt_d = r_wcnt_q + 1'b1;
                end
            end
            S_UPDATE: begin
                w_state_d = S_IDLE;
                if (r_resp_ok_q) begin
                    if (r_cur_q) w_p1_pos_d = r_resp_pos_q;
                    else         w_p0_pos_d = r_resp_pos_q;
                end
                if (w_won) begin
                    w_winner_d = r_cur_q;
                    w_state_d  = S_DONE;
                end else if (!r_timeout_q && r_last_roll_q == 3'd6) begin
                    w_six_d = r_six_q + 2'd1;
                end else begin
                    w_six_d = 2'd0;
                    w_cur_d = ~r_cur_q;
                end
            end
            S_DONE: begin
                w_state_d = S_DONE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // A new game overrides whatever the current state decided, including a response.
        if (new_game) begin
            w_state_d  = S_IDLE;
            w_p0_pos_d = '0;
            w_p1_pos_d = '0;
            w_cur_d    = 1'b0;
            w_six_d    = 2'd0;
            w_err_d    = 1'b0;
            w_winner_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_lfsr_q      <= LFSR_SEED;
            r_p0_pos_q    <= '0;
            r_p1_pos_q    <= '0;
            r_cur_q       <= 1'b0;
            r_last_roll_q <= '0;
            r_six_q       <= '0;
            r_wcnt_q      <= '0;
            r_resp_pos_q  <= '0;
            r_resp_ok_q   <= 1'b0;
            r_timeout_q   <= 1'b0;
            r_winner_q    <= 1'b0;
            r_err_q       <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_lfsr_q      <= w_lfsr_d;
            r_p0_pos_q    <= w_p0_pos_d;
            r_p1_pos_q    <= w_p1_pos_d;
            r_cur_q       <= w_cur_d;
            r_last_roll_q <= w_last_roll_d;
            r_six_q       <= w_six_d;
            r_wcnt_q      <= w_wcnt_d;
            r_resp_pos_q  <= w_resp_pos_d;
            r_resp_ok_q   <= w_resp_ok_d;
            r_timeout_q   <= w_timeout_d;
            r_winner_q    <= w_winner_d;
            r_err_q       <= w_err_d;
        end
    end

    assign mv_req_valid = (r_state_q == S_REQ) || (r_state_q == S_WAIT);
    assign mv_position  = mv_req_valid ? w_cur_pos : 7'd0;
    assign mv_dice      = mv_req_valid ? r_last_roll_q : 3'd0;
    assign cur_player   = r_cur_q;
    assign p0_pos       = r_p0_pos_q;
    assign p1_pos       = r_p1_pos_q;
    assign last_roll    = r_last_roll_q;
    assign busy         = (r_state_q != S_IDLE) && (r_state_q != S_DONE);
    assign game_over    = (r_state_q == S_DONE);
    assign winner       = r_winner_q;
    assign err          = r_err_q;

endmodule
`default_nettype wire
